// File: rtl/enc_seq_prio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : enc_pkg
//  Purpose  : Shared types and helpers for the sequential priority encoder.
//             - state_e    : IDLE / EMIT controller states
//             - lsb_index  : index of the lowest set bit of a vector
//             - is_onehot  : true when exactly one bit of a vector is set
//  Revision : 1.0  initial release
// ============================================================================
package enc_pkg;

    // Widest request vector the helpers accept; callers zero-extend into it.
    localparam int MAX_N = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // Scan from the top down so the last hit is the lowest set bit.
    // Returns 0 for an all-zero vector.
    function automatic int unsigned lsb_index(input logic [MAX_N-1:0] vec);
        int unsigned r;
        r = 0;
        for (int i = MAX_N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r = unsigned'(i);
            end
        end
        return r;
    endfunction

    // v & (v - 1) removes the lowest set bit; a one-hot vector becomes zero.
    function automatic logic is_onehot(input logic [MAX_N-1:0] vec);
        logic [MAX_N-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return (vec != '0) && ((vec & (vec - one)) == '0);
    endfunction

endpackage : enc_pkg
`default_nettype wire

// File: rtl/enc_seq_prio_if.sv
`default_nettype none
// ============================================================================
//  Module   : enc_seq_prio_if
//  Purpose  : Request/index handshake bundle for enc_seq_prio.
//             in_valid/in_ready/in_req      : request vector channel
//             out_valid/out_ready/out_idx/out_last : index channel
//             zero_err                      : all-zero vector accepted pulse
//             master = producer/consumer side, slave = encoder side.
//  Revision : 1.0  initial release
// ============================================================================
interface enc_seq_prio_if #(
    parameter int N = 8,
    parameter int W = 3
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_req;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_last;
    logic         zero_err;

    modport master (
        output in_valid,
        output in_req,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_idx,
        input  out_last,
        input  zero_err
    );

    modport slave (
        input  in_valid,
        input  in_req,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_idx,
        output out_last,
        output zero_err
    );
endinterface : enc_seq_prio_if
`default_nettype wire

// File: rtl/enc_seq_prio_lsb_enc.sv
`default_nettype none
// ============================================================================
//  Module   : prio_lsb_enc
//  Purpose  : Combinational lowest-set-bit encoder.
//  Ports    : vec [N-1:0] in  - vector to encode
//             idx [W-1:0] out - index of the lowest set bit (0 if none)
//             any         out - at least one bit of vec is set
//  Revision : 1.0  initial release
// ============================================================================
module prio_lsb_enc
    import enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [MAX_N-1:0] w_vec_ext;

    always_comb begin
        w_vec_ext         = '0;
        w_vec_ext[N-1:0]  = vec;
        idx               = W'(lsb_index(w_vec_ext));
        any               = |vec;
    end

endmodule : prio_lsb_enc
`default_nettype wire

// File: rtl/enc_seq_prio.sv
`default_nettype none
// ============================================================================
//  Module   : enc_seq_prio
//  Purpose  : Sequential N:log2(N) priority encoder. Takes a multi-hot request
//             vector and emits the index of every set bit, lowest first, one
//             index per output handshake.
//  Ports    : clk   in  - rising-edge clock
//             rst_n in  - asynchronous active-low reset
//             bus   slave modport of enc_seq_prio_if (request in, index out,
//                   zero_err pulse)
//  Revision : 1.0  initial release
// ============================================================================
module enc_seq_prio
    import enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    enc_seq_prio_if.slave bus
);

    generate
        if (N < 2 || N > MAX_N || W != $clog2(N)) begin : g_param_err
            $error("enc_seq_prio: need 2 <= N <= MAX_N and W == clog2(N)");
        end
    endgenerate

    state_e         state_q, state_d;
    logic [N-1:0]   pend_q, pend_d;
    logic           zero_err_q, zero_err_d;

    logic [W-1:0]     w_idx;
    logic             w_any;
    logic             w_last;
    logic [N-1:0]     w_clr_mask;
    logic [MAX_N-1:0] w_pend_ext;

    prio_lsb_enc #(
        .N (N),
        .W (W)
    ) u_lsb_enc (
        .vec (pend_q),
        .idx (w_idx),
        .any (w_any)
    );

    always_comb begin
        w_pend_ext        = '0;
        w_pend_ext[N-1:0] = pend_q;
        w_last            = is_onehot(w_pend_ext);
        w_clr_mask        = '0;
        w_clr_mask[w_idx] = 1'b1;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            zero_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            zero_err_q <= zero_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        zero_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (|bus.in_req) begin
                        pend_d  = bus.in_req;
                        state_d = EMIT;
                    end else begin
                        // Empty vector is consumed, only flagged.
                        zero_err_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    pend_d = pend_q & ~w_clr_mask;
                    if (w_last) begin
                        state_d = IDLE;
                    end
                end
                // Never sit in EMIT with nothing left to send.
                if (!w_any) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: derived from state and pend only, never from out_ready.
    // pend is zero outside EMIT, so out_idx reads 0 there.
    // ------------------------------------------------------------------
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == EMIT);
        bus.out_idx   = w_idx;
        bus.out_last  = (state_q == EMIT) && w_last;
        bus.zero_err  = zero_err_q;
    end

endmodule : enc_seq_prio
`default_nettype wire
